// File: rtl/dbus_mem_responder.sv
// Data-bus responder: a 64-bit word RAM with byte-strobe writes, answering one request at a time after LATENCY cycles.
// Optional macro DBUS_RESP_RAND_STALL_EN adds 0..3 pseudo-random extra wait cycles per request.

package dbus_pkg;
   typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;
endpackage

module dbus_mem_responder
   import dbus_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
   parameter int unsigned LATENCY     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp
);

   // state  | meaning
   // S_IDLE | waiting for dreq.valid; accepts in this state only
   // S_WAIT | request latched, counting down to the response cycle
   // S_RESP | data_ok high for one cycle; a pending write commits at its end
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [63:0] WIN_BYTES = 64'(DEPTH_WORDS) * 64'd8;

   function automatic logic in_win(input logic [63:0] a);
      return (a >= BASE_ADDR) && ((a - BASE_ADDR) < WIN_BYTES);
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [63:0] a);
      logic [63:0] off;
      off = (a - BASE_ADDR) >> 3;
      return off[AW-1:0];
   endfunction

   state_t        state_q;
   logic [4:0]    cnt_q;
   logic [AW-1:0] idx_q;
   logic          win_q;
   logic          wr_q;
   logic [7:0]    strobe_q;
   logic [63:0]   wdata_q;
   logic          data_ok_q;
   logic [63:0]   rdata_q;
   logic [63:0]   mem_q [DEPTH_WORDS];

   logic          accept;
   logic [1:0]    extra;
   logic [4:0]    load_cnt;
   logic [4:0]    cnt_dec;
   logic          to_resp;
   logic [AW-1:0] rd_idx;
   logic          rd_win;
   logic          unused_size;

   assign accept   = dreq.valid && (state_q == S_IDLE);
   assign load_cnt = 5'(LATENCY - 1) + {3'b000, extra};
   assign cnt_dec  = cnt_q - 5'd1;
   assign to_resp  = (accept && (load_cnt == 5'd0)) ||
                     ((state_q == S_WAIT) && (cnt_dec == 5'd0));
   // With a one-cycle path the read is sampled in the accept cycle, before the fields are latched.
   assign rd_idx   = (state_q == S_IDLE) ? word_idx(dreq.addr) : idx_q;
   assign rd_win   = (state_q == S_IDLE) ? in_win(dreq.addr) : win_q;
   assign unused_size = ^dreq.size;

`ifdef DBUS_RESP_RAND_STALL_EN
   logic [7:0] lfsr_q;
   assign extra = lfsr_q[1:0];
   always_ff @(posedge clk) begin
      if (reset)
         lfsr_q <= 8'hA5;
      else if (accept)
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end
`else
   assign extra = 2'd0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         idx_q     <= '0;
         win_q     <= 1'b0;
         wr_q      <= 1'b0;
         strobe_q  <= 8'h00;
         wdata_q   <= 64'd0;
         data_ok_q <= 1'b0;
         rdata_q   <= 64'd0;
      end else begin
         data_ok_q <= to_resp;
         if (to_resp)
            rdata_q <= rd_win ? mem_q[rd_idx] : 64'd0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  idx_q    <= word_idx(dreq.addr);
                  win_q    <= in_win(dreq.addr);
                  wr_q     <= (dreq.strobe != 8'h00);
                  strobe_q <= dreq.strobe;
                  wdata_q  <= dreq.data;
                  cnt_q    <= load_cnt;
                  state_q  <= (load_cnt == 5'd0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_dec;
               if (cnt_dec == 5'd0)
                  state_q <= S_RESP;
            end
            S_RESP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // RAM is not reset; an asserted reset in the response cycle drops the write.
   always_ff @(posedge clk) begin
      if (!reset && (state_q == S_RESP) && wr_q && win_q) begin
         for (int i = 0; i < 8; i++)
            if (strobe_q[i])
               mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
   end

   always_comb begin
      dresp         = '0;
      dresp.addr_ok = accept && !reset;
      dresp.data_ok = data_ok_q;
      dresp.data    = rdata_q;
   end

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Scoreboard bench for dbus_mem_responder: directed protocol cases plus random traffic against a reference word array.
module tb_dbus_mem_responder;
   import dbus_pkg::*;

   localparam int          LAT   = 2;
   localparam int          DEPTH = 256;
   localparam logic [63:0] BASE  = 64'h8000_0000;

   logic       clk = 1'b0;
   logic       reset;
   dbus_req_t  dreq;
   dbus_resp_t dresp;

   always #5 clk = ~clk;

   dbus_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .dreq  (dreq),
      .dresp (dresp)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [63:0] data;
      int          lat;
      bit          chkd;
   } exp_t;

   exp_t        sb_q[$];
   logic [63:0] ref_mem [DEPTH];
   bit          known   [DEPTH];
   logic [7:0]  lfsr_m;

   task automatic next_extra(output int e);
`ifdef DBUS_RESP_RAND_STALL_EN
      e      = int'(lfsr_m[1:0]);
      lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`else
      e = 0;
`endif
   endtask

   // Called right after a falling edge; returns at the falling edge inside the response cycle.
   task automatic req(input logic [63:0] addr, input logic [7:0] strb, input logic [63:0] d, input bit keep);
      exp_t e;
      int   ex, lat, wi;
      bit   seen, win;
      win = (addr >= BASE) && (addr < BASE + 64'(DEPTH) * 64'd8);
      wi  = win ? int'((addr - BASE) >> 3) : 0;
      e.data = win ? ref_mem[wi] : 64'd0;
      e.chkd = win ? known[wi] : 1'b1;
      if (win && strb != 8'h00) begin
         for (int i = 0; i < 8; i++)
            if (strb[i]) ref_mem[wi][8*i +: 8] = d[8*i +: 8];
         if (strb == 8'hFF) known[wi] = 1'b1;
      end
      next_extra(ex);
      e.lat = LAT + ex;
      sb_q.push_back(e);
      dreq.valid  = 1'b1;
      dreq.addr   = addr;
      dreq.size   = MSIZE8;
      dreq.strobe = strb;
      dreq.data   = d;
      #1 check("addr_ok", 64'(dresp.addr_ok), 64'd1);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         seen = dresp.data_ok;
      end
      e = sb_q.pop_front();
      if (!seen) check("timeout", 64'd0, 64'd1);
      else begin
         check("latency", 64'(lat), 64'(e.lat));
         if (e.chkd) check("rdata", dresp.data, e.data);
      end
      if (keep) begin
         #1 check("no_acc_in_resp", 64'(dresp.addr_ok), 64'd0);
      end else
         dreq.valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          ex;
      logic [63:0] w0;
      reset = 1'b1;
      dreq  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         known[i]   = 1'b0;
         ref_mem[i] = 64'd0;
      end
      repeat (3) @(negedge clk);
      dreq.valid = 1'b1;
      #1;
      check("rst_addr_ok", 64'(dresp.addr_ok), 64'd0);
      check("rst_data_ok", 64'(dresp.data_ok), 64'd0);
      check("rst_data", dresp.data, 64'd0);
      dreq.valid = 1'b0;
      @(negedge clk);
      reset  = 1'b0;
      lfsr_m = 8'hA5;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         req(BASE + 64'(8 * i), 8'hFF, {$urandom, $urandom}, 1'b0);
      end

      @(negedge clk);
      req(BASE + 64'h10, 8'hFF, 64'h1122334455667788, 1'b0);
      @(negedge clk);
      check("data_ok_after_resp", 64'(dresp.data_ok), 64'd0);
      req(BASE + 64'h10, 8'h00, 64'd0, 1'b0);
      check("rd_full_word", dresp.data, 64'h1122334455667788);
      @(negedge clk);
      req(BASE + 64'h10, 8'h03, 64'h0000_0000_0000_AABB, 1'b0);
      @(negedge clk);
      req(BASE + 64'h10, 8'h00, 64'd0, 1'b0);
      check("rd_partial_merge", dresp.data, 64'h112233445566AABB);

      w0 = ref_mem[0];
      @(negedge clk);
      req(64'h0000_1000, 8'h00, 64'd0, 1'b0);
      @(negedge clk);
      req(64'h0000_1000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      @(negedge clk);
      req(BASE + 64'h800, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      @(negedge clk);
      req(BASE, 8'h00, 64'd0, 1'b0);
      check("oow_no_alias", dresp.data, w0);
      @(negedge clk);
      req(BASE + 64'h7F8, 8'hFF, 64'hCAFE_0000_BEEF_1234, 1'b0);
      @(negedge clk);
      req(BASE + 64'h7F8, 8'h00, 64'd0, 1'b0);

      @(negedge clk);
      req(BASE + 64'h18, 8'h00, 64'd0, 1'b1);
      @(negedge clk);
      req(BASE + 64'h20, 8'h00, 64'd0, 1'b0);

      // write accepted, then reset during its wait cycle
      @(negedge clk);
      dreq.valid  = 1'b1;
      dreq.addr   = BASE + 64'h10;
      dreq.strobe = 8'hFF;
      dreq.data   = 64'hDEAD_BEEF_DEAD_BEEF;
      #1 check("abort_addr_ok", 64'(dresp.addr_ok), 64'd1);
      next_extra(ex);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("abort_data_ok_rst", 64'(dresp.data_ok), 64'd0);
      end
      dreq.valid = 1'b0;
      reset      = 1'b0;
      lfsr_m     = 8'hA5;
      repeat (4) begin
         @(negedge clk);
         check("abort_no_data_ok", 64'(dresp.data_ok), 64'd0);
      end
      req(BASE + 64'h10, 8'h00, 64'd0, 1'b0);
      check("abort_word_kept", dresp.data, 64'h112233445566AABB);

      for (int n = 0; n < 300; n++) begin
         logic [7:0] s;
         s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
         @(negedge clk);
         req(BASE + 64'(8 * $urandom_range(0, 15)), s, {$urandom, $urandom}, 1'b0);
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
